// File: rtl/serial_adder_au_pkg.sv
// Shared definitions for the bit-serial adder arithmetic unit:
// FSM state encoding and the default operand width.
package serial_adder_au_pkg;

   localparam int DEFAULT_WIDTH = 5;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

endpackage : serial_adder_au_pkg

// File: rtl/serial_adder_au_full_adder.sv
// One-bit full adder built from gate primitives; the only arithmetic cell
// of the serial adder.
module full_adder
   import serial_adder_au_pkg::*;
(
   output logic sum,
   output logic cout,
   input  logic a,
   input  logic b,
   input  logic cin
);

   logic w_ab_xor;
   logic w_ab_and;
   logic w_prop_and;

   xor g_x0 (w_ab_xor, a, b);
   xor g_x1 (sum, w_ab_xor, cin);
   and g_a0 (w_ab_and, a, b);
   and g_a1 (w_prop_and, w_ab_xor, cin);
   or  g_o0 (cout, w_ab_and, w_prop_and);

endmodule : full_adder

// File: rtl/serial_adder_au.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flip-flop,
// LSB first, with sum / carry-out / signed overflow and a one-cycle done pulse.
module serial_adder_au
   import serial_adder_au_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow
);

   localparam int            CW       = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_a_sr;
   logic [WIDTH-1:0] r_b_sr;
   logic [WIDTH-2:0] r_sum_sr;
   logic             r_c;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry_out;
   logic             r_overflow;

   logic             w_s;
   logic             w_cout;
   logic [WIDTH-1:0] w_sum_full;

   full_adder u_fa (
      .sum  (w_s),
      .cout (w_cout),
      .a    (r_a_sr[0]),
      .b    (r_b_sr[0]),
      .cin  (r_c)
   );

   // The new bit enters at the MSB; on the last RUN cycle this is the whole sum.
   assign w_sum_full = {w_s, r_sum_sr};

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the values from before this edge, whatever the statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: datapath registers are reset too, so an aborted run leaves
         // no stale operand or partial sum behind.
         r_state     <= ST_IDLE;
         r_a_sr      <= '0;
         r_b_sr      <= '0;
         r_sum_sr    <= '0;
         r_c         <= 1'b0;
         r_cnt       <= '0;
         r_sum       <= '0;
         r_carry_out <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_a_sr  <= a;
                  r_b_sr  <= b;
                  r_c     <= cin;
                  r_cnt   <= '0;
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               r_c      <= w_cout;
               r_a_sr   <= r_a_sr >> 1;
               r_b_sr   <= r_b_sr >> 1;
               r_sum_sr <= w_sum_full[WIDTH-1:1];
               r_cnt    <= r_cnt + CW'(1);
               if (r_cnt == CNT_LAST) begin
                  // r_c here is the carry into the MSB.
                  r_sum       <= w_sum_full;
                  r_carry_out <= w_cout;
                  r_overflow  <= r_c ^ w_cout;
                  r_state     <= ST_DONE;
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign ready     = (r_state == ST_IDLE);
   assign done      = (r_state == ST_DONE);
   assign sum       = r_sum;
   assign carry_out = r_carry_out;
   assign overflow  = r_overflow;

endmodule : serial_adder_au
